// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the iterative RV32M multiply/divide unit.
interface muldiv_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        busy;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_rd, out_result, busy
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, flush, out_ready,
    output in_ready, out_valid, out_rd, out_result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply or restoring divide on magnitudes,
// sign fix-up afterwards, with a single-cycle path for divide-by-zero, overflow and zero multiplies.
module muldiv_unit #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  function automatic logic [31:0] neg32(input logic n, input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return n ? -s : s;
  endfunction

  function automatic logic [63:0] neg64(input logic n, input logic [63:0] v);
    logic signed [63:0] s;
    s = v;
    return n ? -s : s;
  endfunction

  logic        accept;
  logic        rs1_sgn, rs2_sgn, n1, n2;
  logic [31:0] ua, ub;
  logic        div_zero, div_ovf, mul_zero, early;
  logic [31:0] early_res;

  assign accept   = bus.in_valid & ~bus.flush;
  assign rs1_sgn  = (bus.in_op == OP_MULH) | (bus.in_op == OP_MULHSU) |
                    (bus.in_op == OP_DIV)  | (bus.in_op == OP_REM);
  assign rs2_sgn  = (bus.in_op == OP_MULH) | (bus.in_op == OP_DIV) | (bus.in_op == OP_REM);
  assign n1       = rs1_sgn & bus.in_rs1[31];
  assign n2       = rs2_sgn & bus.in_rs2[31];
  assign ua       = neg32(n1, bus.in_rs1);
  assign ub       = neg32(n2, bus.in_rs2);

  assign div_zero = bus.in_op[2] & (bus.in_rs2 == 32'd0);
  assign div_ovf  = ((bus.in_op == OP_DIV) | (bus.in_op == OP_REM)) &
                    (bus.in_rs1 == 32'h8000_0000) & (bus.in_rs2 == 32'hFFFF_FFFF);
  assign mul_zero = EARLY_OUT & ~bus.in_op[2] & ((bus.in_rs1 == 32'd0) | (bus.in_rs2 == 32'd0));
  assign early    = div_zero | div_ovf | mul_zero;
  assign early_res = div_zero ? (bus.in_op[1] ? bus.in_rs1 : 32'hFFFF_FFFF) :
                     div_ovf  ? (bus.in_op[1] ? 32'd0 : 32'h8000_0000) : 32'd0;

  // Per-iteration datapath: multiply adds into the upper half and shifts right,
  // divide shifts the next dividend bit into the trial remainder.
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [63:0] prod_fix;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  assign div_shift = {rem_q, acc_q[31]};
  assign div_trial = div_shift - {1'b0, a_q};
  assign prod_fix  = neg64(qneg_q, acc_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_d     = rd_q;
    op_d     = op_q;
    a_d      = a_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = bus.in_op;
          rd_d   = bus.in_rd;
          qneg_d = n1 ^ n2;
          rneg_d = n1;
          if (early) begin
            result_d = early_res;
            state_d  = S_DONE;
          end else begin
            cnt_d   = 5'd31;
            state_d = S_RUN;
            rem_d   = 32'd0;
            a_d     = bus.in_op[2] ? ub : ua;
            acc_d   = {32'd0, bus.in_op[2] ? ua : ub};
          end
        end
      end
      S_RUN: begin
        if (op_q[2]) begin
          if (div_trial[32]) begin
            rem_d = div_shift[31:0];
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
          end else begin
            rem_d = div_trial[31:0];
            acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
          end
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (op_q[2])
          result_d = op_q[1] ? neg32(rneg_q, rem_q) : neg32(qneg_q, acc_q[31:0]);
        else
          result_d = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  // Operand/accumulator registers are fully loaded on every accept and need no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    acc_q  <= acc_d;
    rem_q  <= rem_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_result = result_q;
  assign bus.out_rd     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic results, latency, early path, hold, flush, reset.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muldiv_if bus();

  muldiv_unit #(.EARLY_OUT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rdy,
                        output logic [31:0] res, output logic [4:0] ord, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_rd     = rd;
    bus.out_ready = rdy;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.out_result;
    ord = bus.out_rd;
    if (rdy) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_result !== 32'd0) begin errors++; $display("FAIL reset_out_result got %h exp 0", bus.out_result); end
    checks++; if (bus.out_rd !== 5'd0) begin errors++; $display("FAIL reset_out_rd got %0d exp 0", bus.out_rd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_arith;
    logic [2:0]  ops [10] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd0, 3'd1};
    logic [31:0] av  [10] = '{32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd3, 32'hFFFF_FFFE};
    logic [31:0] bv  [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'd4, 32'd3};
    logic [31:0] ev  [10] = '{32'hFFFF_FFEB, 32'h0000_0006, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'd12, 32'hFFFF_FFFF};
    logic [4:0]  rdv [10] = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd0, 5'd31};
    logic [31:0] res;
    logic [4:0]  ord;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], av[i], bv[i], rdv[i], 1'b1, res, ord, lat);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL arith_res[%0d] op %0d got %h exp %h", i, ops[i], res, ev[i]); end
      checks++; if (ord !== rdv[i]) begin errors++; $display("FAIL arith_rd[%0d] got %0d exp %0d", i, ord, rdv[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL arith_lat[%0d] got %0d exp 33", i, lat); end
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL arith_consume[%0d] in_ready %b out_valid %b exp 1/0", i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_early;
    logic [2:0]  ops [5] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd0};
    logic [31:0] av  [5] = '{32'd1234, 32'd1234, 32'h8000_0000, 32'h8000_0000, 32'd0};
    logic [31:0] bv  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] ev  [5] = '{32'hFFFF_FFFF, 32'd1234, 32'h8000_0000, 32'd0, 32'd0};
    logic [31:0] res;
    logic [4:0]  ord;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], av[i], bv[i], 5'd3, 1'b1, res, ord, lat);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL early_res[%0d] got %h exp %h", i, res, ev[i]); end
      checks++; if (lat !== 0) begin errors++; $display("FAIL early_lat[%0d] got %0d exp 0", i, lat); end
      checks++; if (ord !== 5'd3) begin errors++; $display("FAIL early_rd[%0d] got %0d exp 3", i, ord); end
    end
  endtask

  task automatic test_hold;
    logic [31:0] res;
    logic [4:0]  ord;
    int          lat;
    run_op(3'd5, 32'd100, 32'd7, 5'd17, 1'b0, res, ord, lat);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL hold_res got %h exp 0000000e", res); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd14 || bus.out_rd !== 5'd17 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_stable[%0d] valid %b res %h rd %0d in_ready %b exp 1/0000000e/17/0",
                           i, bus.out_valid, bus.out_result, bus.out_rd, bus.in_ready);
      end
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_consume valid %b in_ready %b exp 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_flush;
    logic [31:0] res;
    logic [4:0]  ord;
    int          lat;
    bit          seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 3'd5; bus.in_rs1 = 32'd100; bus.in_rs2 = 32'd7;
    bus.in_rd = 5'd4; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle busy %b in_ready %b exp 0/1", bus.busy, bus.in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid got %b exp 0", seen); end
    run_op(3'd7, 32'd100, 32'd7, 5'd21, 1'b1, res, ord, lat);
    checks++; if (res !== 32'd2 || ord !== 5'd21) begin
      errors++; $display("FAIL flush_next_op res %h rd %0d exp 00000002/21", res, ord);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_rs1 = 32'd9; bus.in_rs2 = 32'd9;
    bus.in_rd = 5'd9; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_result !== 32'd0 || bus.out_rd !== 5'd0) begin
      errors++; $display("FAIL reset_mid busy %b valid %b res %h rd %0d exp 0/0/0/0",
                         bus.busy, bus.out_valid, bus.out_result, bus.out_rd);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got %b exp 1", bus.in_ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_rs1    = 32'd0;
    bus.in_rs2    = 32'd0;
    bus.in_rd     = 5'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset;
    test_arith;
    test_early;
    test_hold;
    test_flush;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
